alu_vec_pipe: RTL and testbench
===============================

Name: alu_vec_pipe

Overview:
- Next-generation lane-parallel vector ALU for the SIMD datapath; replaces the purely combinational vector ALU stage.
- Splits WIDTH_V into NUM_LANES elements of BITS_INDEX bits and registers every result behind a valid/ready handshake.
- Adds a multi-cycle unsigned dot-product reduction that processes DOT_LPC lanes per cycle.
- Sits between the vector register-file read stage and writeback.

Parameters:
- WIDTH_V, 128, vector width in bits.
- BITS_INDEX, 8, element width in bits; WIDTH_V must be a multiple of BITS_INDEX.
- NUM_LANES, WIDTH_V/BITS_INDEX, derived element count.
- DOT_LPC, 4, lanes reduced per cycle in the dot op; must divide NUM_LANES.
- ACC_W, 2*BITS_INDEX+$clog2(NUM_LANES), dot accumulator width (default 20).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block accepts an operation this cycle.
- a  in  WIDTH_V  vector operand A.
- b  in  WIDTH_V  vector operand B.
- c  in  BITS_INDEX  scalar operand.
- opcode  in  3  operation select.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH_V  registered result.
- flags  out  NUM_LANES*4  per-lane flags {V,N,Z,C} at bits [4i+3:4i].
- busy  out  1  high while a dot product is iterating.

Behaviour:
- Reset: when rst_n=0 at a clock edge, state=IDLE, out_valid=0, result=0, flags=0, busy=0, accumulator=0. A reset during DOT or HOLD aborts the operation and discards the pending result.
- Handshake:
  - An operation is accepted when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==HOLD && out_ready).
  - The result is transferred when out_valid && out_ready.
  - result and flags stay stable while out_valid=1 and out_ready=0.
- Opcodes (lane i, BITS_INDEX-bit modular arithmetic):
  - 000 add a+b: C=carry-out, V=signed overflow.
  - 001 sub a-b: C=no-borrow (a>=b unsigned), V=signed overflow.
  - 010 mul: low BITS_INDEX bits of a*b unsigned; C=1 if the high half is nonzero; V=0.
  - 011 pass: result=a; C=V=0.
  - 100 set: every lane =c; C=V=0.
  - 101 xor a^b: C=V=0.
  - 110 shl a<<c[$clog2(BITS_INDEX)-1:0]: C=last bit shifted out; V=0.
  - 111 dot.
  - For all ops: Z=(lane result==0), N=lane result MSB.
- Element-wise ops (000-110): latency 1. Accepted at edge k, out_valid=1 after edge k. The state goes to HOLD.
- Dot (111):
  - On acceptance, latch a and b, clear the accumulator, set busy=1, state=DOT, beat counter=0.
  - Each DOT cycle adds the DOT_LPC unsigned lane products for lanes [beat*DOT_LPC .. beat*DOT_LPC+DOT_LPC-1], then increments beat.
  - After NUM_LANES/DOT_LPC beats (default 4), write the result and enter HOLD with out_valid=1 and busy=0.
  - Total latency from accept edge to out_valid: NUM_LANES/DOT_LPC cycles.
  - result[ACC_W-1:0]=sum, upper bits 0, so the sum never overflows.
  - Flags: only lane 0 is meaningful (Z=sum==0, N=0, C=0, V=0); all other lanes' flags are 0.
  - in_ready=0 throughout DOT.
- States:
  - IDLE -> HOLD on element-wise accept; IDLE -> DOT on dot accept.
  - DOT -> HOLD on the final beat.
  - HOLD -> IDLE on out_ready && !in_valid.
  - HOLD -> HOLD or DOT when out_ready && in_valid: a new op is accepted in the same cycle the old result drains, giving one element-wise op per cycle.
  - HOLD stays put if !out_ready.
- Simultaneous drain and dot accept in HOLD: out_valid drops next cycle; busy rises.
- Operands are don't-care when not accepted; opcode is sampled only at acceptance.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, result=0, flags=0, in_ready=1 after release.
- Add wrap: lanes a=0xFF, b=0x01, opcode 000 -> next cycle every lane 0x00 with C=1, Z=1, N=0, V=0. Lane a=0x7F, b=0x01 -> 0x80 with V=1, N=1.
- Set/pass/backpressure: opcode 100, c=0x5A -> all lanes 0x5A. Hold out_ready=0 for 3 cycles -> result stable, in_ready=0. Then stream 3 pass ops with out_ready=1 -> one result per cycle, in order.
- Dot:
  - a lanes=1..16, b lanes all 2 -> out_valid exactly 4 cycles after accept, result=272 (0x110) in low 20 bits, upper bits 0, busy high for 4 cycles.
  - a=b=all 0xFF -> 16*65025=1040400 (0xFE010), no truncation.
- Reset mid-dot: assert rst_n=0 on beat 2 -> no out_valid, busy=0. The next add op completes normally.
- Shift/mul: a=0x81, c=1, opcode 110 -> 0x02, C=1. a=0x10, b=0x10, opcode 010 -> 0x00, C=1, Z=1.

Source files
------------

// File: rtl/alu_vec_pipe.sv
// Lane-parallel vector ALU with a registered valid/ready result stage and a multi-beat unsigned dot product.
// Element ops take 1 cycle and a dot takes NUM_LANES/DOT_LPC cycles; a held result blocks new ops until the consumer drains it.
module alu_vec_pipe #(
    parameter int WIDTH_V    = 128,
    parameter int BITS_INDEX = 8,
    parameter int NUM_LANES  = WIDTH_V / BITS_INDEX,
    parameter int DOT_LPC    = 4,
    parameter int ACC_W      = 2 * BITS_INDEX + $clog2(NUM_LANES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH_V-1:0]        a,
    input  logic [WIDTH_V-1:0]        b,
    input  logic [BITS_INDEX-1:0]     c,
    input  logic [2:0]                opcode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH_V-1:0]        result,
    output logic [NUM_LANES*4-1:0]    flags,
    output logic                      busy
);
    localparam int NUM_BEATS = NUM_LANES / DOT_LPC;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int SH_W      = $clog2(BITS_INDEX);
    localparam int M         = BITS_INDEX - 1;

    typedef enum logic [1:0] {IDLE, DOT, HOLD} state_t;

    state_t                    state_q, state_d;
    logic [WIDTH_V-1:0]        result_q, result_d;
    logic [NUM_LANES*4-1:0]    flags_q, flags_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [WIDTH_V-1:0]        a_q, a_d, b_q, b_d;

    logic [WIDTH_V-1:0]        elem_res;
    logic [NUM_LANES*4-1:0]    elem_flags;
    logic [ACC_W-1:0]          partial;
    logic [ACC_W-1:0]          dot_sum;
    logic                      accept;

    always_comb begin
        logic [BITS_INDEX-1:0]   la, lb, r;
        logic [BITS_INDEX:0]     ext;
        logic [2*BITS_INDEX-1:0] prod;
        logic                    cf, vf;
        elem_res   = '0;
        elem_flags = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            la   = a[i*BITS_INDEX +: BITS_INDEX];
            lb   = b[i*BITS_INDEX +: BITS_INDEX];
            r    = '0;
            ext  = '0;
            prod = '0;
            cf   = 1'b0;
            vf   = 1'b0;
            case (opcode)
                3'b000: begin
                    ext = {1'b0, la} + {1'b0, lb};
                    r   = ext[M:0];
                    cf  = ext[BITS_INDEX];
                    vf  = (la[M] == lb[M]) && (r[M] != la[M]);
                end
                3'b001: begin
                    r  = la - lb;
                    cf = (la >= lb);
                    vf = (la[M] != lb[M]) && (r[M] != la[M]);
                end
                3'b010: begin
                    prod = {{BITS_INDEX{1'b0}}, la} * {{BITS_INDEX{1'b0}}, lb};
                    r    = prod[M:0];
                    cf   = |prod[2*BITS_INDEX-1:BITS_INDEX];
                end
                3'b011: r = la;
                3'b100: r = c;
                3'b101: r = la ^ lb;
                3'b110: begin
                    // The extra top bit catches the last bit pushed out of the lane
                    ext = {1'b0, la} << c[SH_W-1:0];
                    r   = ext[M:0];
                    cf  = ext[BITS_INDEX];
                end
                default: r = '0;
            endcase
            elem_res[i*BITS_INDEX +: BITS_INDEX] = r;
            elem_flags[i*4 +: 4] = {vf, r[M], (r == '0), cf};
        end
    end

    always_comb begin
        logic [2*BITS_INDEX-1:0] prod;
        int                      idx;
        partial = '0;
        for (int j = 0; j < DOT_LPC; j++) begin
            idx     = int'(beat_q) * DOT_LPC + j;
            prod    = {{BITS_INDEX{1'b0}}, a_q[idx*BITS_INDEX +: BITS_INDEX]}
                    * {{BITS_INDEX{1'b0}}, b_q[idx*BITS_INDEX +: BITS_INDEX]};
            partial = partial + {{(ACC_W-2*BITS_INDEX){1'b0}}, prod};
        end
        dot_sum = acc_q + partial;
    end

    assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == DOT);
    assign result    = result_q;
    assign flags     = flags_q;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        acc_d    = acc_q;
        beat_d   = beat_q;
        a_d      = a_q;
        b_d      = b_q;
        case (state_q)
            IDLE, HOLD: begin
                if (state_q == HOLD && out_ready && !in_valid)
                    state_d = IDLE;
                if (accept) begin
                    if (opcode == 3'b111) begin
                        a_d     = a;
                        b_d     = b;
                        acc_d   = '0;
                        beat_d  = '0;
                        state_d = DOT;
                    end else begin
                        result_d = elem_res;
                        flags_d  = elem_flags;
                        state_d  = HOLD;
                    end
                end
            end
            DOT: begin
                acc_d  = dot_sum;
                beat_d = beat_q + BEAT_W'(1);
                if (beat_q == BEAT_W'(NUM_BEATS - 1)) begin
                    result_d             = '0;
                    result_d[ACC_W-1:0]  = dot_sum;
                    flags_d              = '0;
                    flags_d[1]           = (dot_sum == '0);
                    state_d              = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
            acc_q    <= '0;
            beat_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            acc_q    <= acc_d;
            beat_q   <= beat_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end
endmodule

// File: tb/tb_alu_vec_pipe.sv
// Scoreboard bench for alu_vec_pipe: directed corner cases plus randomized ops against a lane-level arithmetic model.
module tb_alu_vec_pipe;
    localparam int W = 8;
    localparam int L = 16;

    typedef struct packed {
        logic [127:0] res;
        logic [63:0]  flg;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  a, b;
    logic [7:0]    c;
    logic [2:0]    opcode;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  result;
    logic [63:0]   flags;
    logic          busy;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rand_rdy = 1'b0;

    alu_vec_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .opcode(opcode), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    function automatic exp_t model(input logic [2:0] op, input logic [127:0] va,
                                   input logic [127:0] vb, input logic [7:0] vc);
        exp_t e;
        int   x, y, r, s, sh;
        bit   cf, vf;
        longint sum;
        e = '0;
        if (op == 3'b111) begin
            sum = 0;
            for (int i = 0; i < L; i++)
                sum += longint'(va[8*i +: 8]) * longint'(vb[8*i +: 8]);
            e.res = 128'(sum);
            e.flg[1] = (sum == 0);
            return e;
        end
        for (int i = 0; i < L; i++) begin
            x = int'(va[8*i +: 8]);
            y = int'(vb[8*i +: 8]);
            cf = 0; vf = 0;
            case (op)
                3'b000: begin s = x + y; r = s % 256; cf = s > 255;
                              s = sgn(x) + sgn(y); vf = (s > 127) || (s < -128); end
                3'b001: begin r = (x - y + 256) % 256; cf = x >= y;
                              s = sgn(x) - sgn(y); vf = (s > 127) || (s < -128); end
                3'b010: begin s = x * y; r = s % 256; cf = s > 255; end
                3'b011: r = x;
                3'b100: r = int'(vc);
                3'b101: r = x ^ y;
                default: begin
                    sh = int'(vc) % W;
                    r  = (x << sh) % 256;
                    cf = (sh != 0) && (((x >> (W - sh)) & 1) == 1);
                end
            endcase
            e.res[8*i +: 8] = r[7:0];
            e.flg[4*i +: 4] = {vf, r > 127, r == 0, cf};
        end
        return e;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: any valid output must match the head of the scoreboard, every cycle it is held
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_out_valid", 128'(out_valid), 128'(0));
            end else begin
                chk("result", result, sb_q[0].res);
                chk("flags", 128'(flags), 128'(sb_q[0].flg));
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic issue(input logic [2:0] op, input logic [127:0] va,
                         input logic [127:0] vb, input logic [7:0] vc);
        int n = 0;
        in_valid = 1'b1; opcode = op; a = va; b = vb; c = vc;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 128'(in_ready), 128'(1));
        else sb_q.push_back(model(op, va, vb, vc));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = rnd128(); b = rnd128(); opcode = 3'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 128'(sb_q.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] va, vb;
        int lat, busy_cnt;

        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        a = rnd128(); b = rnd128(); c = 8'h11; opcode = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_result", result, 128'(0));
        chk("rst_flags", 128'(flags), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        @(posedge clk);
        #1;

        issue(3'b000, {16{8'hFF}}, {16{8'h01}}, 8'h00);
        issue(3'b000, {16{8'h7F}}, {16{8'h01}}, 8'h00);
        issue(3'b110, {16{8'h81}}, rnd128(), 8'h01);
        issue(3'b010, {16{8'h10}}, {16{8'h10}}, 8'h00);
        drain();

        out_ready = 1'b0;
        issue(3'b100, rnd128(), rnd128(), 8'h5A);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_out_valid", 128'(out_valid), 128'(1));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) issue(3'b011, rnd128(), rnd128(), 8'h00);
        drain();

        for (int i = 0; i < L; i++) va[8*i +: 8] = 8'(i + 1);
        vb = {16{8'h02}};
        issue(3'b111, va, vb, 8'h00);
        lat = 0; busy_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i - 1;
                break;
            end
            if (busy) busy_cnt++;
        end
        chk("dot_latency", 128'(lat), 128'(4));
        chk("dot_busy_cycles", 128'(busy_cnt), 128'(4));
        chk("dot_busy_low_at_result", 128'(busy), 128'(0));
        chk("dot_in_ready_low", 128'(sb_q.size()), 128'(1));
        drain();
        issue(3'b111, {16{8'hFF}}, {16{8'hFF}}, 8'h00);
        drain();

        issue(3'b111, rnd128(), rnd128(), 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("middot_rst_out_valid", 128'(out_valid), 128'(0));
        chk("middot_rst_busy", 128'(busy), 128'(0));
        repeat (6) @(negedge clk);
        chk("middot_no_late_result", 128'(out_valid), 128'(0));
        @(posedge clk);
        #1;
        issue(3'b000, rnd128(), rnd128(), 8'h00);
        drain();

        rand_rdy = 1'b1;
        repeat (300) issue(3'($urandom_range(0, 7)), rnd128(), rnd128(), 8'($urandom));
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
